// File: rtl/vec_alu_pkg.sv
// Shared types for the vector ALU pipeline: op encoding and NZP flag constants.
package vec_alu_pkg;

  typedef enum logic [2:0] {
    ADD = 3'b000,
    SUB = 3'b001,
    MUL = 3'b010,
    NOT = 3'b011,
    AND = 3'b100,
    OR  = 3'b101,
    SHL = 3'b110,
    SRA = 3'b111
  } alu_op_t;

  typedef logic [2:0] nzp_t;

  localparam nzp_t NZP_NEG  = 3'b100;
  localparam nzp_t NZP_ZERO = 3'b010;
  localparam nzp_t NZP_POS  = 3'b001;

endpackage

// File: rtl/vec_alu_lane.sv
// Combinational single-lane ALU: one op on a/b plus NZP classification.
// Inactive lanes pass b through untouched with cleared flags.
module vec_alu_lane
  import vec_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  alu_op_t          op,
  input  logic             active,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output nzp_t             nzp
);

  localparam int SH_W = $clog2(WIDTH);

  logic [WIDTH-1:0] raw;
  logic             shift_big;
  logic [SH_W-1:0]  shamt;

  always_comb begin
    // Any bit above the shift-amount field means the shift covers the whole word.
    shift_big = |(b >> SH_W);
    shamt     = b[SH_W-1:0];
    raw       = '0;
    case (op)
      ADD:     raw = a + b;
      SUB:     raw = a - b;
      MUL:     raw = a * b;
      NOT:     raw = ~a;
      AND:     raw = a & b;
      OR:      raw = a | b;
      SHL:     raw = shift_big ? '0 : (a << shamt);
      SRA:     raw = shift_big ? {WIDTH{a[WIDTH-1]}} : $unsigned($signed(a) >>> shamt);
      default: raw = '0;
    endcase

    if (active) begin
      result = raw;
      if (raw[WIDTH-1])   nzp = NZP_NEG;
      else if (raw == '0) nzp = NZP_ZERO;
      else                nzp = NZP_POS;
    end else begin
      result = b;
      nzp    = '0;
    end
  end

endmodule

// File: rtl/vec_alu_pipe.sv
// Two-stage pipelined multi-lane ALU with per-lane swizzled A operand,
// lane masking and a valid/ready handshake that tolerates full backpressure.
module vec_alu_pipe
  import vec_alu_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int LANES     = 4,
  parameter int ARG_SLOTS = 4,
  parameter int TAG_W     = 6,
  localparam int SEL_W    = $clog2(ARG_SLOTS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [2:0]                in_op,
  input  logic [LANES*WIDTH-1:0]    in_dest,
  input  logic [ARG_SLOTS*WIDTH-1:0] in_arg,
  input  logic [LANES*SEL_W-1:0]    in_swizzle,
  input  logic [LANES-1:0]          in_lane_mask,
  input  logic [TAG_W-1:0]          in_tag,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*WIDTH-1:0]    out_result,
  output logic [LANES*3-1:0]        out_nzp,
  output logic [LANES-1:0]          out_lane_mask,
  output logic [TAG_W-1:0]          out_tag
);

  logic                         s1_valid_q, s1_valid_d;
  alu_op_t                      s1_op_q, s1_op_d;
  logic [LANES-1:0]             s1_mask_q, s1_mask_d;
  logic [TAG_W-1:0]             s1_tag_q, s1_tag_d;
  logic [LANES-1:0][WIDTH-1:0]  s1_a_q, s1_a_d;
  logic [LANES-1:0][WIDTH-1:0]  s1_b_q, s1_b_d;

  logic                         s2_valid_q, s2_valid_d;
  logic [LANES-1:0][WIDTH-1:0]  s2_res_q, s2_res_d;
  nzp_t [LANES-1:0]             s2_nzp_q, s2_nzp_d;
  logic [LANES-1:0]             s2_mask_q, s2_mask_d;
  logic [TAG_W-1:0]             s2_tag_q, s2_tag_d;

  logic [LANES-1:0][WIDTH-1:0]  swz_a;
  logic [LANES-1:0][WIDTH-1:0]  lane_res;
  nzp_t [LANES-1:0]             lane_nzp;

  logic s1_load, s2_load;

  // A stage may take new contents when it is empty or its contents move on.
  assign s2_load  = !s2_valid_q || out_ready;
  assign s1_load  = !s1_valid_q || s2_load;
  assign in_ready = s1_load;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign swz_a[gi] = in_arg[in_swizzle[gi*SEL_W +: SEL_W]*WIDTH +: WIDTH];

      vec_alu_lane #(
        .WIDTH (WIDTH)
      ) u_lane (
        .op     (s1_op_q),
        .active (s1_mask_q[gi]),
        .a      (s1_a_q[gi]),
        .b      (s1_b_q[gi]),
        .result (lane_res[gi]),
        .nzp    (lane_nzp[gi])
      );
    end
  endgenerate

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_mask_d  = s1_mask_q;
    s1_tag_d   = s1_tag_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s2_valid_d = s2_valid_q;
    s2_res_d   = s2_res_q;
    s2_nzp_d   = s2_nzp_q;
    s2_mask_d  = s2_mask_q;
    s2_tag_d   = s2_tag_q;

    if (s1_load) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_op_d   = alu_op_t'(in_op);
        s1_mask_d = in_lane_mask;
        s1_tag_d  = in_tag;
        s1_a_d    = swz_a;
        s1_b_d    = in_dest;
      end
    end

    // Data regs only move with a real transaction so idle outputs keep their last value.
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_res_d  = lane_res;
        s2_nzp_d  = lane_nzp;
        s2_mask_d = s1_mask_q;
        s2_tag_d  = s1_tag_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= ADD;
      s1_mask_q  <= '0;
      s1_tag_q   <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_res_q   <= '0;
      s2_nzp_q   <= '0;
      s2_mask_q  <= '0;
      s2_tag_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_mask_q  <= s1_mask_d;
      s1_tag_q   <= s1_tag_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s2_valid_q <= s2_valid_d;
      s2_res_q   <= s2_res_d;
      s2_nzp_q   <= s2_nzp_d;
      s2_mask_q  <= s2_mask_d;
      s2_tag_q   <= s2_tag_d;
    end
  end

  assign out_valid     = s2_valid_q;
  assign out_result    = s2_res_q;
  assign out_nzp       = s2_nzp_q;
  assign out_lane_mask = s2_mask_q;
  assign out_tag       = s2_tag_q;

endmodule

// File: tb/tb_vec_alu_pipe.sv
// Randomised and directed bench for vec_alu_pipe with an in-bench queue model.
module tb_vec_alu_pipe;

  localparam int W  = 32;
  localparam int L  = 4;
  localparam int S  = 4;
  localparam int T  = 6;
  localparam int SW = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [L*W-1:0]   in_dest;
  logic [S*W-1:0]   in_arg;
  logic [L*SW-1:0]  in_swizzle;
  logic [L-1:0]     in_lane_mask;
  logic [T-1:0]     in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [L*W-1:0]   out_result;
  logic [L*3-1:0]   out_nzp;
  logic [L-1:0]     out_lane_mask;
  logic [T-1:0]     out_tag;

  vec_alu_pipe #(
    .WIDTH     (W),
    .LANES     (L),
    .ARG_SLOTS (S),
    .TAG_W     (T)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_op         (in_op),
    .in_dest       (in_dest),
    .in_arg        (in_arg),
    .in_swizzle    (in_swizzle),
    .in_lane_mask  (in_lane_mask),
    .in_tag        (in_tag),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_nzp       (out_nzp),
    .out_lane_mask (out_lane_mask),
    .out_tag       (out_tag)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [L*W-1:0] res;
    logic [L*3-1:0] nzp;
    logic [L-1:0]   mask;
    logic [T-1:0]   tag;
    int             acc;
    bit             exact;
  } exp_t;

  exp_t q[$];
  int   occ = 0;
  bit   exact_mode = 0;
  bit   bp_rand = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: begin p = 64'(a) * 64'(b); return p[31:0]; end
      3'd3: return ~a;
      3'd4: return a & b;
      3'd5: return a | b;
      3'd6: return (b >= 32) ? 32'h0 : (a << b);
      default: return (b >= 32) ? {32{a[31]}} : $unsigned($signed(a) >>> b);
    endcase
  endfunction

  function automatic logic [2:0] ref_nzp(input logic [31:0] r);
    if (r[31]) return 3'b100;
    if (r == 0) return 3'b010;
    return 3'b001;
  endfunction

  function automatic exp_t build_exp();
    exp_t e;
    int sel;
    logic [31:0] a, b, r;
    for (int i = 0; i < L; i++) begin
      sel = int'(in_swizzle[i*SW +: SW]);
      a = in_arg[sel*W +: W];
      b = in_dest[i*W +: W];
      if (in_lane_mask[i]) begin
        r = ref_op(in_op, a, b);
        e.res[i*W +: W] = r;
        e.nzp[i*3 +: 3] = ref_nzp(r);
      end else begin
        e.res[i*W +: W] = b;
        e.nzp[i*3 +: 3] = 3'b000;
      end
    end
    e.mask  = in_lane_mask;
    e.tag   = in_tag;
    e.acc   = cyc;
    e.exact = exact_mode;
    return e;
  endfunction

  // Compare process: one check pass per cycle at the falling edge.
  bit             stall_prev = 0;
  logic [L*W-1:0] prev_res;
  logic [L*3-1:0] prev_nzp;
  logic [L-1:0]   prev_mask;
  logic [T-1:0]   prev_tag;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      stall_prev = 0;
    end else begin
      check("in_ready", 128'(in_ready), 128'((occ < 2) || out_ready));
      if (stall_prev) begin
        check("hold_valid", 128'(out_valid), 128'd1);
        check("hold_result", 128'(out_result), 128'(prev_res));
        check("hold_nzp", 128'(out_nzp), 128'(prev_nzp));
        check("hold_tag", 128'(out_tag), 128'(prev_tag));
        check("hold_mask", 128'(out_lane_mask), 128'(prev_mask));
      end
      if (out_valid) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL stale_output: actual out_valid=1 tag=%0d required no output", out_tag);
        end else begin
          e = q[0];
          check("result", 128'(out_result), 128'(e.res));
          check("nzp", 128'(out_nzp), 128'(e.nzp));
          check("lane_mask", 128'(out_lane_mask), 128'(e.mask));
          check("tag", 128'(out_tag), 128'(e.tag));
          if (e.exact) check("latency", 128'(cyc - e.acc), 128'd2);
          else         check("latency_min", 128'((cyc - e.acc) >= 2), 128'd1);
          if (out_ready) begin
            void'(q.pop_front());
            occ--;
            $display("txn out tag=%0d mask=%b result=%h nzp=%b", out_tag, out_lane_mask, out_result, out_nzp);
          end
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(build_exp());
        occ++;
      end
      stall_prev = out_valid && !out_ready;
      prev_res   = out_result;
      prev_nzp   = out_nzp;
      prev_mask  = out_lane_mask;
      prev_tag   = out_tag;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bp_rand) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic set_txn(input logic [2:0] op, input logic [L*W-1:0] dest, input logic [S*W-1:0] arg,
                         input logic [L*SW-1:0] swz, input logic [L-1:0] mask, input logic [T-1:0] tag);
    in_op        = op;
    in_dest      = dest;
    in_arg       = arg;
    in_swizzle   = swz;
    in_lane_mask = mask;
    in_tag       = tag;
    in_valid     = 1'b1;
  endtask

  task automatic wait_accept();
    bit ok = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: actual in_ready=0 required 1 within 200 cycles");
    end
  endtask

  task automatic send(input logic [2:0] op, input logic [L*W-1:0] dest, input logic [S*W-1:0] arg,
                      input logic [L*SW-1:0] swz, input logic [L-1:0] mask, input logic [T-1:0] tag);
    set_txn(op, dest, arg, swz, mask, tag);
    wait_accept();
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (q.size() == 0) break;
    end
    @(posedge clk);
    #1;
    check("drain_empty", 128'(q.size()), 128'd0);
  endtask

  function automatic logic [31:0] rnd_b();
    int r;
    r = $urandom_range(0, 3);
    if (r == 0) return 32'($urandom_range(0, 70));
    if (r == 1) return 32'h0;
    return $urandom;
  endfunction

  initial begin
    logic [L*W-1:0] d;
    logic [S*W-1:0] g;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_op = '0; in_dest = '0;
    in_arg = '0; in_swizzle = '0; in_lane_mask = '0; in_tag = '0;

    #1;
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_result", 128'(out_result), 128'd0);
    check("rst_nzp", 128'(out_nzp), 128'd0);
    check("rst_mask", 128'(out_lane_mask), 128'd0);
    check("rst_tag", 128'(out_tag), 128'd0);
    check("rst_in_ready_or0", 128'(in_ready), 128'd1);

    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

    check("pin_add", 128'(ref_op(3'd0, 32'd1, 32'd10)), 128'd11);
    check("pin_sub_neg", 128'(ref_op(3'd1, 32'd5, 32'd7)), 128'hFFFFFFFE);
    check("pin_nzp_neg", 128'(ref_nzp(32'hFFFFFFFE)), 128'b100);
    check("pin_nzp_zero", 128'(ref_nzp(ref_op(3'd1, 32'd7, 32'd7))), 128'b010);
    check("pin_shl31", 128'(ref_op(3'd6, 32'd1, 32'd31)), 128'h80000000);
    check("pin_shl32", 128'(ref_op(3'd6, 32'd1, 32'd32)), 128'h0);
    check("pin_sra40", 128'(ref_op(3'd7, 32'h80000000, 32'd40)), 128'hFFFFFFFF);
    check("pin_sra1", 128'(ref_op(3'd7, 32'h40000000, 32'd1)), 128'h20000000);
    check("pin_mul", 128'(ref_op(3'd2, 32'd3, 32'h10)), 128'h30);

    // Directed, no stall: exact latency checked on every result.
    out_ready  = 1'b1;
    exact_mode = 1;
    send(3'd0, {4{32'd10}}, {32'd4, 32'd3, 32'd2, 32'd1}, {2'd0, 2'd1, 2'd2, 2'd3}, 4'hF, 6'd10);
    send(3'd0, {4{32'd10}}, {32'd4, 32'd3, 32'd2, 32'd1}, {2'd0, 2'd1, 2'd2, 2'd3}, 4'hF, 6'd11);
    send(3'd1, {4{32'd7}}, {32'd0, 32'd0, 32'd7, 32'd5}, {2'd1, 2'd1, 2'd0, 2'd0}, 4'hF, 6'd12);
    send(3'd6, {32'd0, 32'd33, 32'd32, 32'd31}, {32'd0, 32'd0, 32'd0, 32'd1}, 8'h00, 4'hF, 6'd13);
    send(3'd7, {32'd1, 32'd31, 32'd1, 32'd40}, {32'd0, 32'h40000000, 32'h80000000, 32'd0},
         {2'd2, 2'd1, 2'd2, 2'd1}, 4'hF, 6'd14);
    send(3'd2, {32'h77, 32'h10, 32'h55, 32'h10}, {32'd0, 32'd0, 32'd0, 32'd3}, 8'h00, 4'b0101, 6'd15);
    wait_drain();
    exact_mode = 0;

    // Backpressure: pipe fills after two accepts, then drains in order.
    out_ready = 1'b0;
    send(3'd0, {4{32'd1}}, {4{32'd1}}, 8'h00, 4'hF, 6'd1);
    send(3'd1, {4{32'd2}}, {4{32'd9}}, 8'h1B, 4'hF, 6'd2);
    set_txn(3'd4, {4{32'hF0F0}}, {4{32'hFF00}}, 8'hE4, 4'hF, 6'd3);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_in_ready_low", 128'(in_ready), 128'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_accept();
    send(3'd5, {4{32'h0F}}, {4{32'hF0}}, 8'h00, 4'hF, 6'd4);
    wait_drain();

    // Reset with two transactions in flight: nothing may emerge afterwards.
    send(3'd0, {4{32'd5}}, {4{32'd5}}, 8'h00, 4'hF, 6'd20);
    send(3'd0, {4{32'd6}}, {4{32'd6}}, 8'h00, 4'hF, 6'd21);
    #1 rst = 1'b1;
    #1;
    check("midrst_out_valid", 128'(out_valid), 128'd0);
    check("midrst_result", 128'(out_result), 128'd0);
    check("midrst_nzp", 128'(out_nzp), 128'd0);
    check("midrst_tag", 128'(out_tag), 128'd0);
    check("midrst_mask", 128'(out_lane_mask), 128'd0);
    q.delete();
    occ = 0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    repeat (6) @(posedge clk);
    #1;

    // Random traffic with random backpressure.
    bp_rand = 1;
    for (int n = 0; n < 150; n++) begin
      for (int i = 0; i < L; i++) d[i*W +: W] = rnd_b();
      for (int s = 0; s < S; s++) g[s*W +: W] = ($urandom_range(0, 3) == 0) ? 32'h80000000 : $urandom;
      send(3'($urandom_range(0, 7)), d, g, 8'($urandom), 4'($urandom), 6'($urandom));
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    bp_rand = 0;
    out_ready = 1'b1;
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
